activation_pipe: RTL and testbench

Parametrised, pipelined, multi-channel activation unit for the autoencoder datapath. It replaces the single-lane combinational ReLu stage between each layer's MAC accumulator and the next layer's input buffer. It accepts a vector of CHANNELS signed fixed-point values per beat under a valid/ready handshake. It applies a per-beat selectable activation (ReLU, leaky ReLU, ReLU6, bypass) and returns the result two cycles later with full backpressure support.

---
 rtl/act_if.sv | 24 ++
 rtl/activation_pipe.sv | 103 ++++++++++
 tb/tb_activation_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/act_if.sv
// act_if: valid/ready beat bus between a producer and the activation pipe.
// Ports (signals): in_valid/in_ready/in_mode/in_data form the input beat handshake;
// out_valid/out_ready/out_data form the result beat handshake.
// The slave modport is the activation unit; the master modport is its environment.
interface act_if #(
  parameter int NBITS    = 16,
  parameter int CHANNELS = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_mode;
  logic [NBITS*CHANNELS-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [NBITS*CHANNELS-1:0] out_data;
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/activation_pipe.sv
// activation_pipe: two-stage, multi-channel activation (ReLU, leaky ReLU, ReLU6, bypass) with backpressure.
// Ports: clk (rising edge), rst (async, active-high), bus (act_if.slave: in_valid/in_ready/in_mode/in_data,
// out_valid/out_ready/out_data). Optional feature macro ACT_STATS_EN adds stat_clr (sync clear) and
// neg_count (saturating count of negative accepted input elements).
// in_mode: 0 ReLU, 1 leaky ReLU (slope 2^-LEAK_SHIFT), 2 ReLU6, 3 bypass.
module activation_pipe #(
  parameter int NBITS      = 16,
  parameter int FRAC       = 8,
  parameter int CHANNELS   = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  act_if.slave        bus
`ifdef ACT_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] neg_count
`endif
);
  localparam int W = NBITS * CHANNELS;
  // 6.0 in the fixed-point format, clipped to the largest positive code when it does not fit
  localparam logic signed [63:0] MAX_POS = (64'sd1 <<< (NBITS - 1)) - 64'sd1;
  localparam logic signed [63:0] SIX_RAW = 64'sd6 <<< FRAC;
  localparam logic signed [63:0] SIX_SAT = (SIX_RAW > MAX_POS) ? MAX_POS : SIX_RAW;
  localparam logic [NBITS-1:0]   SIX     = SIX_SAT[NBITS-1:0];
  logic                adv;
  logic                acc;
  logic                v1_q, v1_d;
  logic                v2_q, v2_d;
  logic [1:0]          mode1_q, mode1_d;
  logic [W-1:0]        data1_q, data1_d;
  logic [CHANNELS-1:0] neg1_q, neg1_d;
  logic [CHANNELS-1:0] over1_q, over1_d;
  logic [W-1:0]        out_q, out_d;
  logic [CHANNELS-1:0] neg_in;
  logic [CHANNELS-1:0] over_in;
  logic [W-1:0]        act;
  // Both stages move together; a stalled output freezes the whole pipe, bubbles included.
  assign adv           = bus.out_ready | ~v2_q;
  assign acc           = bus.in_valid & adv;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v2_q;
  assign bus.out_data  = out_q;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [NBITS-1:0] x_in;
    logic signed [NBITS-1:0] x1;
    logic signed [NBITS-1:0] lk;
    assign x_in        = bus.in_data[c*NBITS +: NBITS];
    assign neg_in[c]   = x_in[NBITS-1];
    assign over_in[c]  = x_in > $signed(SIX);
    assign x1          = data1_q[c*NBITS +: NBITS];
    assign lk          = x1 >>> LEAK_SHIFT;
    // Sign and ReLU6 limit were resolved in S1, so S2 is a pure select.
    assign act[c*NBITS +: NBITS] = (mode1_q == 2'd3) ? x1 :
                                   !neg1_q[c]        ? ((mode1_q == 2'd2 && over1_q[c]) ? SIX : x1) :
                                   (mode1_q == 2'd1) ? lk : '0;
  end
  always_comb begin
    v1_d    = adv ? bus.in_valid : v1_q;
    mode1_d = acc ? bus.in_mode : mode1_q;
    data1_d = acc ? bus.in_data : data1_q;
    neg1_d  = acc ? neg_in : neg1_q;
    over1_d = acc ? over_in : over1_q;
    v2_d    = adv ? v1_q : v2_q;
    out_d   = (adv & v1_q) ? act : out_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      mode1_q <= '0;
      data1_q <= '0;
      neg1_q  <= '0;
      over1_q <= '0;
      v2_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      mode1_q <= mode1_d;
      data1_q <= data1_d;
      neg1_q  <= neg1_d;
      over1_q <= over1_d;
      v2_q    <= v2_d;
      out_q   <= out_d;
    end
  end
`ifdef ACT_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  pop;
  logic [32:0] sum;
  always_comb begin
    pop = '0;
    for (int k = 0; k < CHANNELS; k++) pop = pop + {5'd0, neg_in[k]};
    sum   = {1'b0, cnt_q} + {27'd0, pop};
    cnt_d = stat_clr ? '0 : acc ? (sum[32] ? '1 : sum[31:0]) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign neg_count = cnt_q;
`endif
endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed-vector scoreboard bench for activation_pipe.
module tb_activation_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [63:0] sb[$];
  logic [63:0] vin[6];
  logic [63:0] vexp[6][4];
  logic        held = 1'b0;
  logic [63:0] held_d;
  act_if #(.NBITS(16), .CHANNELS(4)) bus ();
`ifdef ACT_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] neg_count;
`endif
  activation_pipe #(.NBITS(16), .FRAC(8), .CHANNELS(4), .LEAK_SHIFT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ACT_STATS_EN
    ,
    .stat_clr(stat_clr),
    .neg_count(neg_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask
  task automatic send(input int v, input int m);
    int n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = vin[v];
    bus.in_mode  = m[1:0];
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) flag("accept_timeout");
    else begin
      sb.push_back(vexp[v][m]);
      n_push++;
    end
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask
  always @(posedge clk) begin
    #1;
    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stall_data", bus.out_data, held_d);
      end
      if (bus.out_valid && bus.out_ready) begin
        held = 1'b0;
        if (sb.size() == 0) flag("unexpected_beat");
        else begin
          chk("beat_data", bus.out_data, sb.pop_front());
          n_pop++;
        end
      end else if (bus.out_valid) begin
        held   = 1'b1;
        held_d = bus.out_data;
      end else held = 1'b0;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vin[0] = pk(16'hF900, 16'h0300, 16'h0000, 16'h8000);
    vexp[0][0] = pk(16'h0000, 16'h0300, 16'h0000, 16'h0000);
    vexp[0][1] = pk(16'hFF20, 16'h0300, 16'h0000, 16'hF000);
    vexp[0][2] = pk(16'h0000, 16'h0300, 16'h0000, 16'h0000);
    vexp[0][3] = vin[0];
    vin[1] = pk(16'hF900, 16'h0300, 16'hFFFF, 16'h7FFF);
    vexp[1][0] = pk(16'h0000, 16'h0300, 16'h0000, 16'h7FFF);
    vexp[1][1] = pk(16'hFF20, 16'h0300, 16'hFFFF, 16'h7FFF);
    vexp[1][2] = pk(16'h0000, 16'h0300, 16'h0000, 16'h0600);
    vexp[1][3] = vin[1];
    vin[2] = pk(16'h0700, 16'h0600, 16'h05FF, 16'hF900);
    vexp[2][0] = pk(16'h0700, 16'h0600, 16'h05FF, 16'h0000);
    vexp[2][1] = pk(16'h0700, 16'h0600, 16'h05FF, 16'hFF20);
    vexp[2][2] = pk(16'h0600, 16'h0600, 16'h05FF, 16'h0000);
    vexp[2][3] = vin[2];
    vin[3] = pk(16'h0001, 16'hFFF8, 16'hFFF7, 16'h0601);
    vexp[3][0] = pk(16'h0001, 16'h0000, 16'h0000, 16'h0601);
    vexp[3][1] = pk(16'h0001, 16'hFFFF, 16'hFFFE, 16'h0601);
    vexp[3][2] = pk(16'h0001, 16'h0000, 16'h0000, 16'h0600);
    vexp[3][3] = vin[3];
    vin[4] = pk(16'hF900, 16'h8000, 16'hFFFF, 16'hFFF8);
    vexp[4][0] = 64'd0;
    vexp[4][1] = pk(16'hFF20, 16'hF000, 16'hFFFF, 16'hFFFF);
    vexp[4][2] = 64'd0;
    vexp[4][3] = vin[4];
    vin[5] = pk(16'h0700, 16'h0600, 16'h05FF, 16'h7FFF);
    vexp[5][0] = vin[5];
    vexp[5][1] = vin[5];
    vexp[5][2] = pk(16'h0600, 16'h0600, 16'h05FF, 16'h0600);
    vexp[5][3] = vin[5];
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef ACT_STATS_EN
    chk("rst_neg_count", {32'd0, neg_count}, 64'd0);
`endif
    rst = 1'b0;
    send(0, 0);
    idle();
    @(negedge clk);
    chk("latency_1edge", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_2edge", {63'd0, bus.out_valid}, 64'd1);
    send(1, 1);
    send(2, 2);
    send(2, 3);
    send(3, 0);
    send(3, 1);
    send(3, 2);
    idle();
    drain();
    rnd = 1'b1;
    for (int i = 0; i < 16; i++) send(i % 6, i % 4);
    idle();
    drain();
    rnd = 1'b0;
    repeat (2) @(negedge clk);
    send(1, 1);
    send(2, 2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("inflight_valid", {63'd0, bus.out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_async_data", bus.out_data, 64'd0);
    sb.delete();
    n_push = n_push - 2;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {63'd0, bus.out_valid}, 64'd0);
    send(3, 1);
    idle();
    @(negedge clk);
    chk("post_rst_lat1", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    chk("post_rst_lat2", {63'd0, bus.out_valid}, 64'd1);
    drain();
`ifdef ACT_STATS_EN
    @(posedge clk);
    #1;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk("stat_cleared", {32'd0, neg_count}, 64'd0);
    send(0, 0);
    send(4, 1);
    send(5, 2);
    idle();
    chk("stat_count6", {32'd0, neg_count}, 64'd6);
    stat_clr = 1'b1;
    send(4, 0);
    idle();
    stat_clr = 1'b0;
    chk("stat_clr_wins", {32'd0, neg_count}, 64'd0);
    drain();
`endif
    chk("beat_count", 64'(n_pop), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
